// File: rtl/input_debouncer_if.sv
// Signal bundle for input_debouncer: raw input and enable in, conditioned level,
// edge strobes and glitch count out.
interface input_debouncer_if #(
  parameter int unsigned GLITCH_W = 8
);
  logic                raw_in;
  logic                enable;
  logic                clean;
  logic                rise;
  logic                fall;
  logic [GLITCH_W-1:0] glitch_count;

  modport master (output raw_in, enable, input clean, rise, fall, glitch_count);
  modport slave  (input raw_in, enable, output clean, rise, fall, glitch_count);
endinterface

// File: rtl/input_debouncer.sv
// Two-flop synchronizer followed by a stability-counting debounce FSM that feeds
// the sequence detector's serial input; counts aborted transitions for debug.
module input_debouncer #(
  parameter int unsigned STABLE_CYCLES = 4,
  parameter logic        RESET_LEVEL   = 1'b0,
  parameter int unsigned GLITCH_W      = 8
) (
  input logic             clock,
  input logic             reset,
  input_debouncer_if.slave bus
);
  localparam int unsigned   CW   = $clog2(STABLE_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(STABLE_CYCLES - 1);

  typedef enum logic [1:0] {LOW, RISE_PEND, HIGH, FALL_PEND} state_t;

  state_t              state;
  logic                sync1;
  logic                sync2;
  logic [CW-1:0]       count;
  logic                clean_q;
  logic                rise_q;
  logic                fall_q;
  logic [GLITCH_W-1:0] glitch_q;

  // Synchronizer keeps shifting even while the filter is disabled.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync1 <= RESET_LEVEL;
      sync2 <= RESET_LEVEL;
    end else begin
      sync1 <= bus.raw_in;
      sync2 <= sync1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= RESET_LEVEL ? HIGH : LOW;
      count    <= '0;
      clean_q  <= RESET_LEVEL;
      rise_q   <= 1'b0;
      fall_q   <= 1'b0;
      glitch_q <= '0;
    end else begin
      rise_q <= 1'b0;
      fall_q <= 1'b0;
      if (bus.enable) begin
        case (state)
          LOW: begin
            if (sync2) begin
              state <= RISE_PEND;
              count <= CW'(1);
            end else begin
              count <= '0;
            end
          end
          RISE_PEND: begin
            if (!sync2) begin
              state <= LOW;
              count <= '0;
              if (glitch_q != '1) glitch_q <= glitch_q + 1'b1;
            end else if (count == LAST) begin
              state   <= HIGH;
              clean_q <= 1'b1;
              rise_q  <= 1'b1;
              count   <= '0;
            end else begin
              count <= count + 1'b1;
            end
          end
          HIGH: begin
            if (!sync2) begin
              state <= FALL_PEND;
              count <= CW'(1);
            end else begin
              count <= '0;
            end
          end
          FALL_PEND: begin
            if (sync2) begin
              state <= HIGH;
              count <= '0;
              if (glitch_q != '1) glitch_q <= glitch_q + 1'b1;
            end else if (count == LAST) begin
              state   <= LOW;
              clean_q <= 1'b0;
              fall_q  <= 1'b1;
              count   <= '0;
            end else begin
              count <= count + 1'b1;
            end
          end
          default: state <= LOW;
        endcase
      end
    end
  end

  assign bus.clean        = clean_q;
  assign bus.rise         = rise_q;
  assign bus.fall         = fall_q;
  assign bus.glitch_count = glitch_q;
endmodule

// File: tb/tb_input_debouncer.sv
// Bench for input_debouncer: directed scenarios plus randomized bouncing input,
// two instances (8-bit and 2-bit glitch counters) checked against a run-length model.
module tb_input_debouncer;
  localparam int unsigned S = 4;

  logic clock;
  logic reset;
  logic raw_in;
  logic enable;

  int tests = 0;
  int fails = 0;

  input_debouncer_if #(.GLITCH_W(8)) if_a ();
  input_debouncer_if #(.GLITCH_W(2)) if_b ();

  assign if_a.raw_in = raw_in;
  assign if_a.enable = enable;
  assign if_b.raw_in = raw_in;
  assign if_b.enable = enable;

  input_debouncer #(.STABLE_CYCLES(S), .RESET_LEVEL(1'b0), .GLITCH_W(8)) dut_a (
    .clock (clock),
    .reset (reset),
    .bus   (if_a.slave)
  );

  input_debouncer #(.STABLE_CYCLES(S), .RESET_LEVEL(1'b0), .GLITCH_W(2)) dut_b (
    .clock (clock),
    .reset (reset),
    .bus   (if_b.slave)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  // Reference: clean flips after S consecutive enabled sync samples disagree with it;
  // a disagreeing run broken by an agreeing sample counts as one glitch.
  logic m_s1 = 1'b0, m_s2 = 1'b0, m_clean = 1'b0, m_rise = 1'b0, m_fall = 1'b0;
  int   m_run = 0;
  int   m_gl  = 0;

  always @(posedge clock or posedge reset) begin
    logic samp;
    if (reset) begin
      m_s1 = 1'b0; m_s2 = 1'b0; m_clean = 1'b0;
      m_rise = 1'b0; m_fall = 1'b0; m_run = 0; m_gl = 0;
    end else begin
      samp   = m_s2;
      m_s2   = m_s1;
      m_s1   = raw_in;
      m_rise = 1'b0;
      m_fall = 1'b0;
      if (enable) begin
        if (samp != m_clean) begin
          m_run++;
          if (m_run == S) begin
            m_clean = samp;
            m_rise  = samp;
            m_fall  = !samp;
            m_run   = 0;
          end
        end else begin
          if (m_run > 0) m_gl++;
          m_run = 0;
        end
      end
    end
  end

  always @(negedge clock) begin
    chk("clean_a", if_a.clean, m_clean);
    chk("rise_a",  if_a.rise,  m_rise);
    chk("fall_a",  if_a.fall,  m_fall);
    chk("glitch_a", if_a.glitch_count, (m_gl > 255) ? 255 : m_gl);
    chk("clean_b", if_b.clean, m_clean);
    chk("glitch_b", if_b.glitch_count, (m_gl > 3) ? 3 : m_gl);
    chk("rise_fall_excl", if_a.rise & if_a.fall, 0);
  end

  task automatic step(input logic r);
    @(negedge clock);
    raw_in = r;
  endtask

  initial begin
    int nr;
    int nf;
    logic pat [9];
    int sat_exp [5];
    int hold;
    logic val;

    pat = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    sat_exp = '{1, 2, 3, 3, 3};

    // Reset held with raw_in high, released at t=12.
    reset  = 1'b1;
    raw_in = 1'b1;
    enable = 1'b1;
    #11;
    chk("rst_clean", if_a.clean, 0);
    chk("rst_rise", if_a.rise, 0);
    chk("rst_glitch", if_a.glitch_count, 0);
    #1 reset = 1'b0;
    @(posedge clock);
    repeat (4) @(posedge clock);
    #1 chk("pre_rise_clean", if_a.clean, 0);
    @(posedge clock);
    #1 chk("rise_clean", if_a.clean, 1);
    chk("rise_pulse", if_a.rise, 1);
    @(posedge clock);
    #1 chk("rise_drop", if_a.rise, 0);

    // Qualified fall.
    step(1'b0);
    nf = 0;
    repeat (10) begin
      @(negedge clock);
      nf += int'(if_a.fall);
    end
    chk("fall_count", nf, 1);
    chk("fall_clean", if_a.clean, 0);

    // Bounce from LOW.
    nr = 0;
    for (int i = 0; i < 9; i++) begin
      @(negedge clock);
      nr += int'(if_a.rise);
      raw_in = pat[i];
    end
    repeat (8) begin
      @(negedge clock);
      nr += int'(if_a.rise);
    end
    chk("bounce_rises", nr, 1);
    chk("bounce_glitch", if_a.glitch_count, 2);
    chk("bounce_clean", if_a.clean, 1);

    // Enable freeze in RISE_PEND with count 2.
    step(1'b0);
    repeat (10) @(negedge clock);
    step(1'b1);
    repeat (4) @(negedge clock);
    enable = 1'b0;
    repeat (6) begin
      @(posedge clock);
      #1 chk("frz_clean", if_a.clean, 0);
      chk("frz_rise", if_a.rise, 0);
    end
    @(negedge clock);
    enable = 1'b1;
    @(posedge clock);
    #1 chk("resume1_clean", if_a.clean, 0);
    @(posedge clock);
    #1 chk("resume2_clean", if_a.clean, 1);
    chk("resume2_rise", if_a.rise, 1);

    // Async reset while in FALL_PEND.
    repeat (3) @(negedge clock);
    step(1'b0);
    step(1'b0);
    step(1'b1);
    repeat (2) @(negedge clock);
    chk("pend_clean", if_a.clean, 1);
    chk("pend_glitch", if_a.glitch_count, 2);
    #2 reset = 1'b1;
    #1 chk("async_clean", if_a.clean, 0);
    chk("async_glitch_a", if_a.glitch_count, 0);
    chk("async_glitch_b", if_b.glitch_count, 0);
    @(negedge clock);
    raw_in = 1'b0;
    #2 reset = 1'b0;
    repeat (8) @(negedge clock);

    // Saturation of the 2-bit counter.
    for (int g = 0; g < 5; g++) begin
      step(1'b1);
      step(1'b0);
      repeat (5) @(negedge clock);
      chk("sat_b", if_b.glitch_count, sat_exp[g]);
      chk("sat_a", if_a.glitch_count, g + 1);
    end

    // Randomized bouncing input with occasional disable and async reset.
    for (int n = 0; n < 1500; n++) begin
      hold = $urandom_range(1, 8);
      val  = 1'($urandom_range(0, 1));
      for (int h = 0; h < hold; h++) begin
        @(negedge clock);
        raw_in = val;
        enable = ($urandom_range(0, 9) != 0);
        if ($urandom_range(0, 299) == 0) begin
          #1 reset = 1'b1;
          #2 reset = 1'b0;
        end
      end
    end
    repeat (3) @(negedge clock);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
